// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: field codes, edit FSM states and per-field blink masks
package clock_ctrl_pkg;
  typedef enum logic [2:0] {
    F_NONE  = 3'd0,
    F_SEC   = 3'd1,
    F_MIN   = 3'd2,
    F_HOUR  = 3'd3,
    F_DAY   = 3'd4,
    F_MONTH = 3'd5,
    F_YEAR  = 3'd6
  } field_t;
  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_EDIT_A = 2'd1,
    S_EDIT_B = 2'd2,
    S_EDIT_C = 2'd3
  } ctrl_state_t;
  localparam logic [7:0] M_HOUR_DAY  = 8'hC0;
  localparam logic [7:0] M_MIN_MONTH = 8'h30;
  localparam logic [7:0] M_SEC       = 8'h0C;
  localparam logic [7:0] M_YEAR      = 8'h0F;
  function automatic ctrl_state_t next_state(input ctrl_state_t s);
    return ctrl_state_t'(s + 2'd1);
  endfunction
  function automatic field_t field_of(input ctrl_state_t s, input logic clk_view);
    return (s == S_EDIT_A) ? (clk_view ? F_HOUR : F_DAY) :
           (s == S_EDIT_B) ? (clk_view ? F_MIN : F_MONTH) :
           (s == S_EDIT_C) ? (clk_view ? F_SEC : F_YEAR) : F_NONE;
  endfunction
  function automatic logic [7:0] mask_of(input field_t f);
    return (f == F_HOUR || f == F_DAY) ? M_HOUR_DAY :
           (f == F_MIN || f == F_MONTH) ? M_MIN_MONTH :
           (f == F_SEC) ? M_SEC :
           (f == F_YEAR) ? M_YEAR : 8'h00;
  endfunction
endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: raw buttons and view switch in, edit commands and blink mask out
interface clock_set_ctrl_if;
  import clock_ctrl_pkg::*;
  logic sw_mode, butt_increase, butt_decrease, butt_change;
  logic edit_active, inc_pulse, dec_pulse, run_en;
  field_t field_sel;
  logic [7:0] blank_mask;
  modport master (
    output sw_mode, butt_increase, butt_decrease, butt_change,
    input  edit_active, field_sel, inc_pulse, dec_pulse, run_en, blank_mask
  );
  modport slave (
    input  sw_mode, butt_increase, butt_decrease, butt_change,
    output edit_active, field_sel, inc_pulse, dec_pulse, run_en, blank_mask
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and press/auto-repeat event for one active-low button
module button_conditioner #(
  parameter int CNT_W           = 29,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_butt_n,
  output logic o_evt
);
  logic r_s1, r_s2, r_lvl, r_evt;
  logic [CNT_W-1:0] r_db, r_rep;
  logic w_acc, w_fall, w_rep;
  always_comb begin
    w_acc  = (r_s2 != r_lvl) && (r_db == CNT_W'(DEBOUNCE_CYCLES - 1));
    w_fall = w_acc && r_lvl;
    // a release being accepted this cycle suppresses a coincident repeat
    w_rep  = REPEAT_EN && !r_lvl && !w_acc && (r_rep == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_lvl <= 1'b1;
      r_db  <= '0;
      r_rep <= '0;
      r_evt <= 1'b0;
    end else begin
      r_s1  <= i_butt_n;
      r_s2  <= r_s1;
      r_db  <= (r_s2 == r_lvl || w_acc) ? '0 : r_db + 1'b1;
      r_lvl <= w_acc ? r_s2 : r_lvl;
      r_rep <= w_fall ? CNT_W'(HOLD_CYCLES - 1) :
               w_rep ? CNT_W'(REPEAT_CYCLES - 1) :
               (!r_lvl && r_rep != '0) ? r_rep - 1'b1 : r_rep;
      r_evt <= w_fall || w_rep;
    end
  end
  assign o_evt = r_evt;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: edit-mode FSM, idle timeout and blink mask for the clock/calendar counters
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000,
  parameter int BLINK_CYCLES    = 12_500_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000,
  parameter int CNT_W           = 29
) (
  input logic clk,
  input logic rst,
  clock_set_ctrl_if.slave bus
);
  logic w_inc, w_dec, w_chg, w_live, w_tgl, w_any, w_exp, w_stay, w_tick, w_ph;
  ctrl_state_t r_state, w_nxt;
  field_t r_fld, w_fld;
  logic r_m1, r_m2, r_m3, r_ph, r_edit, r_inc, r_dec, r_run;
  logic [CNT_W-1:0] r_to, r_bc;
  logic [7:0] r_mask;
  button_conditioner #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)) u_inc (.clk(clk), .rst(rst), .i_butt_n(bus.butt_increase), .o_evt(w_inc));
  button_conditioner #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)) u_dec (.clk(clk), .rst(rst), .i_butt_n(bus.butt_decrease), .o_evt(w_dec));
  button_conditioner #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0)) u_chg (.clk(clk), .rst(rst), .i_butt_n(bus.butt_change), .o_evt(w_chg));
  always_comb begin
    w_live = r_state != S_RUN;
    w_tgl  = r_m2 != r_m3;
    w_any  = w_inc || w_dec || w_chg;
    w_exp  = w_live && !w_any && (r_to == CNT_W'(TIMEOUT_CYCLES - 1));
    w_nxt  = (w_live && (w_tgl || w_exp)) ? S_RUN : w_chg ? next_state(r_state) : r_state;
    // commands only land on a field that is still selected next cycle
    w_stay = w_live && (w_nxt == r_state);
    w_tick = w_live && (r_bc == CNT_W'(BLINK_CYCLES - 1));
    w_ph   = (w_nxt != S_RUN) && (r_ph ^ w_tick);
    w_fld  = field_of(w_nxt, r_m2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m1    <= 1'b0;
      r_m2    <= 1'b0;
      r_m3    <= 1'b0;
      r_state <= S_RUN;
      r_to    <= '0;
      r_bc    <= '0;
      r_ph    <= 1'b0;
      r_edit  <= 1'b0;
      r_fld   <= F_NONE;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_run   <= 1'b1;
      r_mask  <= 8'h00;
    end else begin
      r_m1    <= bus.sw_mode;
      r_m2    <= r_m1;
      r_m3    <= r_m2;
      r_state <= w_nxt;
      r_to    <= (!w_live || w_nxt == S_RUN || w_any) ? '0 : r_to + 1'b1;
      r_bc    <= (!w_live || w_nxt == S_RUN || w_tick) ? '0 : r_bc + 1'b1;
      r_ph    <= w_ph;
      r_edit  <= w_nxt != S_RUN;
      r_fld   <= w_fld;
      r_inc   <= w_stay && w_inc && !w_dec;
      r_dec   <= w_stay && w_dec && !w_inc;
      r_run   <= w_nxt == S_RUN;
      r_mask  <= w_ph ? mask_of(w_fld) : 8'h00;
    end
  end
  assign bus.edit_active = r_edit;
  assign bus.field_sel   = r_fld;
  assign bus.inc_pulse   = r_inc;
  assign bus.dec_pulse   = r_dec;
  assign bus.run_en      = r_run;
  assign bus.blank_mask  = r_mask;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed checks of edit FSM, repeat, blink, timeout and reset
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0, n_err = 0, cyc = 0, n_inc = 0, n_dec = 0, t_chg = 0, b_inc = 0, b_dec = 0;
  clock_set_ctrl_if bus();
  clock_set_ctrl #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .BLINK_CYCLES(8),
    .TIMEOUT_CYCLES(100), .CNT_W(29)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.inc_pulse === 1'b1) n_inc <= n_inc + 1;
    if (bus.dec_pulse === 1'b1) n_dec <= n_dec + 1;
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_edit"}, bus.edit_active, 0);
    chk({tag, "_field"}, bus.field_sel, 0);
    chk({tag, "_inc"}, bus.inc_pulse, 0);
    chk({tag, "_dec"}, bus.dec_pulse, 0);
    chk({tag, "_run"}, bus.run_en, 1);
    chk({tag, "_mask"}, bus.blank_mask, 0);
  endtask
  task automatic change_to(input logic [2:0] from_f, input logic [2:0] to_f, input string tag);
    bus.butt_change = 1'b0;
    step(6);
    chk({tag, "_early"}, bus.field_sel, from_f);
    step(1);
    chk(tag, bus.field_sel, to_f);
    chk({tag, "_run"}, bus.run_en, (to_f == 3'd0) ? 1 : 0);
    t_chg = cyc;
    bus.butt_change = 1'b1;
    step(8);
  endtask
  task automatic mark();
    b_inc = n_inc;
    b_dec = n_dec;
  endtask
  initial begin
    bus.sw_mode = 1'b1;
    bus.butt_increase = 1'b1;
    bus.butt_decrease = 1'b1;
    bus.butt_change = 1'b1;
    step(3);
    chk_idle("reset");
    rst = 1'b0;
    step(5);
    chk_idle("post_reset");
    // glitch shorter than the debounce window
    mark();
    bus.butt_change = 1'b0;
    step(3);
    bus.butt_change = 1'b1;
    step(12);
    chk_idle("short_change");
    chk("short_no_inc", n_inc - b_inc, 0);
    // clock view field walk
    change_to(3'd0, 3'd3, "to_hour");
    chk("hour_edit", bus.edit_active, 1);
    change_to(3'd3, 3'd2, "to_min");
    change_to(3'd2, 3'd1, "to_sec");
    change_to(3'd1, 3'd0, "to_none");
    chk_idle("walk_done");
    // calendar view, hold increase 40 cycles
    bus.sw_mode = 1'b0;
    step(5);
    change_to(3'd0, 3'd4, "to_day");
    mark();
    bus.butt_increase = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      chk($sformatf("rep_k%0d", k), bus.inc_pulse,
          (k == 7 || k == 27 || k == 32 || k == 37 || k == 42) ? 1 : 0);
      if (k == 40) bus.butt_increase = 1'b1;
    end
    step(1);
    chk("rep_total", n_inc - b_inc, 5);
    chk("rep_no_dec", n_dec - b_dec, 0);
    change_to(3'd4, 3'd5, "to_month");
    // inc and dec together cancel
    mark();
    bus.butt_increase = 1'b0;
    bus.butt_decrease = 1'b0;
    step(10);
    bus.butt_increase = 1'b1;
    bus.butt_decrease = 1'b1;
    step(8);
    chk("both_no_inc", n_inc - b_inc, 0);
    chk("both_no_dec", n_dec - b_dec, 0);
    chk("both_field", bus.field_sel, 5);
    // change beats inc in the same cycle
    mark();
    bus.butt_change = 1'b0;
    bus.butt_increase = 1'b0;
    step(6);
    chk("chg_inc_early", bus.field_sel, 5);
    step(1);
    chk("chg_inc_year", bus.field_sel, 6);
    bus.butt_change = 1'b1;
    bus.butt_increase = 1'b1;
    step(8);
    chk("chg_inc_no_inc", n_inc - b_inc, 0);
    // view toggle exits edit 3 cycles after the raw change
    mark();
    bus.sw_mode = 1'b1;
    step(2);
    chk("tgl_still_year", bus.field_sel, 6);
    chk("tgl_still_edit", bus.edit_active, 1);
    step(1);
    chk_idle("tgl_exit");
    step(3);
    chk("tgl_no_pulse", (n_inc - b_inc) + (n_dec - b_dec), 0);
    // blink in MIN, then idle timeout
    change_to(3'd0, 3'd3, "blk_hour");
    change_to(3'd3, 3'd2, "blk_min");
    for (int i = 0; i < 20 && bus.blank_mask !== 8'h00; i++) step(1);
    chk("blink_off_seen", bus.blank_mask, 8'h00);
    for (int i = 0; i < 20 && bus.blank_mask !== 8'h30; i++) step(1);
    chk("blink_on_seen", bus.blank_mask, 8'h30);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("blink_k%0d", k), bus.blank_mask, (k < 8) ? 8'h30 : 8'h00);
      step(1);
    end
    chk("blink_on_again", bus.blank_mask, 8'h30);
    while (cyc < t_chg + 99) step(1);
    chk("to_before", bus.field_sel, 2);
    step(1);
    chk_idle("to_expired");
    // reset in the middle of auto-repeat
    change_to(3'd0, 3'd3, "rst_hour");
    bus.butt_increase = 1'b0;
    step(7);
    chk("rst_first_pulse", bus.inc_pulse, 1);
    step(19);
    rst = 1'b1;
    step(1);
    chk_idle("rst_mid");
    bus.butt_increase = 1'b1;
    step(2);
    rst = 1'b0;
    mark();
    step(30);
    chk_idle("rst_after");
    chk("rst_no_pulse", (n_inc - b_inc) + (n_dec - b_dec), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
